// File: rtl/mlaccel_spi_host.sv
// mlaccel_spi_host: mode-0 SPI initiator; streams bytes out MSB first and
// returns MISO bytes assembled LSB first, with CS setup/hold/gap timing.
module mlaccel_spi_host #(
  parameter int CLKDIV   = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_GAP   = 4
) (
  input  logic       clock,
  input  logic       reset,
  output logic       spi_csb,
  output logic       spi_clk,
  output logic       spi_mosi,
  input  logic       spi_miso,
  input  logic       spi_rdy,
  input  logic       spi_err,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       busy,
  output logic       err_flag
);
  typedef enum logic [2:0] {IDLE, SETUP, WAITRDY, SHIFT, NEXT, HOLD, GAP} state_e;
  state_e state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] byte_q, byte_d, rx_shift_q, rx_shift_d, rx_data_q, rx_data_d;
  logic last_q, last_d, csb_q, csb_d, sclk_q, sclk_d, mosi_q, mosi_d;
  logic rx_valid_q, rx_valid_d, err_q, err_d;
  logic [1:0] rdy_sync_q, rdy_sync_d, err_sync_q, err_sync_d;
  logic hs;
  assign tx_ready = !reset && (state_q == IDLE || state_q == NEXT);
  assign hs       = tx_valid && tx_ready;
  assign busy     = state_q != IDLE;
  assign spi_csb  = csb_q;
  assign spi_clk  = sclk_q;
  assign spi_mosi = mosi_q;
  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;
  assign err_flag = err_q;
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 16'd1;
    bit_d      = bit_q;
    byte_d     = byte_q;
    last_d     = last_q;
    csb_d      = csb_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    rdy_sync_d = {rdy_sync_q[0], spi_rdy};
    err_sync_d = {err_sync_q[0], spi_err};
    err_d      = err_q | (err_sync_q[1] & ~csb_q);
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (hs) begin
          byte_d  = tx_data;
          last_d  = tx_last;
          err_d   = 1'b0;
          csb_d   = 1'b0;
          state_d = SETUP;
        end
      end
      SETUP: if (cnt_q == 16'(CS_SETUP - 1)) begin
        cnt_d   = '0;
        state_d = WAITRDY;
      end
      WAITRDY: begin
        cnt_d  = '0;
        bit_d  = '0;
        sclk_d = 1'b0;
        if (rdy_sync_q[1]) begin
          mosi_d  = byte_q[7];
          state_d = SHIFT;
        end
      end
      SHIFT: if (cnt_q == 16'(CLKDIV - 1)) begin
        cnt_d  = '0;
        sclk_d = ~sclk_q;
        if (!sclk_q) rx_shift_d[bit_q] = spi_miso;
        else if (bit_q == 3'd7) begin
          rx_data_d  = rx_shift_q;
          rx_valid_d = 1'b1;
          state_d    = last_q ? HOLD : NEXT;
        end else begin
          bit_d  = bit_q + 3'd1;
          mosi_d = byte_q[3'd6 - bit_q];
        end
      end
      NEXT: begin
        cnt_d = '0;
        if (hs) begin
          byte_d  = tx_data;
          last_d  = tx_last;
          state_d = WAITRDY;
        end
      end
      HOLD: if (cnt_q == 16'(CS_HOLD - 1)) begin
        cnt_d   = '0;
        csb_d   = 1'b1;
        mosi_d  = 1'b0;
        state_d = GAP;
      end
      GAP: if (cnt_q == 16'(CS_GAP - 1)) begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      byte_q     <= '0;
      last_q     <= 1'b0;
      csb_q      <= 1'b1;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      err_q      <= 1'b0;
      rdy_sync_q <= '0;
      err_sync_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      byte_q     <= byte_d;
      last_q     <= last_d;
      csb_q      <= csb_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      err_q      <= err_d;
      rdy_sync_q <= rdy_sync_d;
      err_sync_q <= err_sync_d;
    end
  end
endmodule
